hazard_stall_unit: RTL
======================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter MWAIT_MAX, default 255: the number of consecutive memory-wait cycles after which mem_err latches.
REQ-002 clk  in  1  pipeline clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 IFID_Rs, IFID_Rt  in  5 each  source registers of the instruction in ID.
REQ-005 IFID_UsesRt  in  1  the ID instruction reads Rt.
REQ-006 IFID_Branch  in  1  the ID instruction is a branch resolved in ID.
REQ-007 IDEX_MemRd, IDEX_RegWr  in  1 each  control bits of the EX-stage instruction.
REQ-008 IDEX_Rt, IDEX_Rd  in  5 each  load destination and ALU destination of the EX-stage instruction.
REQ-009 EXMEM_MemRd, EXMEM_MemWr  in  1 each  the MEM-stage instruction accesses data memory.
REQ-010 EXMEM_Rd  in  5  destination register of the MEM-stage instruction.
REQ-011 branch_taken  in  1  the ID branch resolves taken in this cycle.
REQ-012 dmem_ready  in  1  data memory completes the current MEM access in this cycle.
REQ-013 PC_Wr, IFID_Wr  out  1 each  write enables for the PC and the IF/ID register.
REQ-014 IFID_Flush, IDEX_Flush  out  1 each  insert a bubble into IF/ID and ID/EX.
REQ-015 pipe_hold  out  1  freeze IDEX, EXMEM and MEMWR.
REQ-016 stall_cnt  out  16  saturating count of data-stall cycles.
REQ-017 mem_err, hz_err  out  1 each  sticky error flags.

Function
REQ-018 Define eq(x) = (x != 0) && (x == IFID_Rs || (IFID_UsesRt && x == IFID_Rt)).
REQ-019 Load-use hazard LU SHALL be IDEX_MemRd && eq(IDEX_Rt).
REQ-020 Branch hazard BR SHALL be IFID_Branch && ((IDEX_RegWr && eq(IDEX_Rd)) || (EXMEM_MemRd && eq(EXMEM_Rd))).
REQ-021 Define hz = LU || BR, and mw = (EXMEM_MemRd || EXMEM_MemWr) && !dmem_ready.
REQ-022 All outputs SHALL be combinational from the current inputs, with zero-cycle latency to the write enables.
REQ-023 Priority SHALL be mw > hz > branch_taken.
REQ-024 mw: pipe_hold=1, PC_Wr=0, IFID_Wr=0, both flushes 0.
REQ-025 hz && !mw: PC_Wr=0, IFID_Wr=0, IDEX_Flush=1, IFID_Flush=0, pipe_hold=0.
REQ-026 branch_taken && !hz && !mw: IFID_Flush=1, PC_Wr=1, IFID_Wr=1.
REQ-027 Otherwise: PC_Wr=1, IFID_Wr=1, all other control outputs 0.
REQ-028 FSM states SHALL be RUN, STALL and MWAIT, with state registered on clk.
REQ-029 From any state, next state SHALL be MWAIT if mw, else STALL if hz, else RUN.
REQ-030 stall_cnt SHALL increment by 1 on each clock edge where hz && !mw, saturating at 16'hFFFF.
REQ-031 A 2-bit run counter SHALL count consecutive STALL-to-STALL transitions and clear on any other transition.
REQ-032 hz_err SHALL set when the run counter would reach 2, i.e. a third consecutive stall cycle; the legal maximum is 2.
REQ-033 An 8-bit wait counter SHALL increment each edge while mw and clear when mw=0.
REQ-034 mem_err SHALL set when the wait counter reaches MWAIT_MAX; the wait counter SHALL saturate there.
REQ-035 mem_err and hz_err SHALL clear only on reset.
REQ-036 The rules SHALL be unchanged when IFID_Rs == IFID_Rt; a hazard SHALL be reported once.
REQ-037 Register $0 SHALL never create a hazard.

Reset
REQ-038 While rst_n=0: state=RUN, stall_cnt=0, all counters 0, mem_err=0, hz_err=0.
REQ-039 Reset asserted mid-STALL or mid-MWAIT SHALL return to RUN immediately, with no output glitch persisting past release.
REQ-040 Combinational outputs SHALL continue to follow the inputs during reset.

Verification
REQ-041 Load-use: IDEX_MemRd=1, IDEX_Rt=5, IFID_Rs=5 for 1 cycle -> PC_Wr=0, IDEX_Flush=1 for that cycle; stall_cnt=1.
REQ-042 Load feeding a branch: IDEX_MemRd=1, IDEX_Rt=3, IFID_Branch=1, IFID_Rs=3, then next cycle EXMEM_MemRd=1, EXMEM_Rd=3 -> 2 stall cycles; stall_cnt=2; hz_err=0.
REQ-043 Memory wait: EXMEM_MemRd=1 with dmem_ready=0 for 3 cycles while LU=1 -> pipe_hold=1 and IDEX_Flush=0 throughout; stall_cnt unchanged.
REQ-044 Memory timeout: dmem_ready=0 for 255 cycles -> mem_err=1 at the 255th edge; it stays 1 after dmem_ready=1.
REQ-045 Zero register: IDEX_MemRd=1, IDEX_Rt=0, IFID_Rs=0 -> no stall.
REQ-046 Taken branch, no hazard: branch_taken=1 -> IFID_Flush=1, PC_Wr=1.
REQ-047 Stuck hazard: LU held for 3 cycles -> hz_err=1.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-to-hazard-unit signal bundle: decode/execute/memory stage status in,
// PC/pipeline-register write enables, flushes and status flags out.
interface hazard_stall_unit_if;
  logic [4:0]  IFID_Rs;
  logic [4:0]  IFID_Rt;
  logic        IFID_UsesRt;
  logic        IFID_Branch;
  logic        IDEX_MemRd;
  logic        IDEX_RegWr;
  logic [4:0]  IDEX_Rt;
  logic [4:0]  IDEX_Rd;
  logic        EXMEM_MemRd;
  logic        EXMEM_MemWr;
  logic [4:0]  EXMEM_Rd;
  logic        branch_taken;
  logic        dmem_ready;

  logic        PC_Wr;
  logic        IFID_Wr;
  logic        IFID_Flush;
  logic        IDEX_Flush;
  logic        pipe_hold;
  logic [15:0] stall_cnt;
  logic        mem_err;
  logic        hz_err;

  // The pipeline side drives stage status and consumes the controls.
  modport master (
    output IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_Branch,
           IDEX_MemRd, IDEX_RegWr, IDEX_Rt, IDEX_Rd,
           EXMEM_MemRd, EXMEM_MemWr, EXMEM_Rd, branch_taken, dmem_ready,
    input  PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush, pipe_hold,
           stall_cnt, mem_err, hz_err
  );

  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_Branch,
           IDEX_MemRd, IDEX_RegWr, IDEX_Rt, IDEX_Rd,
           EXMEM_MemRd, EXMEM_MemWr, EXMEM_Rd, branch_taken, dmem_ready,
    output PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush, pipe_hold,
           stall_cnt, mem_err, hz_err
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-operand hazard detection with memory-wait hold, stall
// statistics and sticky watchdog flags for stuck stalls and stuck memory.
module hazard_stall_unit #(
  parameter int MWAIT_MAX = 255
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_unit_if.slave hs
);

  typedef enum logic [1:0] {RUN, STALL, MWAIT} state_t;

  localparam logic [7:0] WAIT_LIM = 8'(MWAIT_MAX);

  state_t      state_q, state_d;
  logic        lu, br, hz, mw;
  logic        stall_to_stall;
  logic [1:0]  run_cnt_q;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q;
  logic        mem_err_q, hz_err_q;

  // Register $0 is hard-wired zero, so it never carries a real dependency.
  function automatic logic src_match(input logic [4:0] x, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (x != 5'd0) && ((x == rs) || (uses_rt && (x == rt)));
  endfunction

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the if/else chain can leave it unassigned and infer a latch.
  always_comb begin
    lu = hs.IDEX_MemRd && src_match(hs.IDEX_Rt, hs.IFID_Rs, hs.IFID_Rt, hs.IFID_UsesRt);
    br = hs.IFID_Branch &&
         ((hs.IDEX_RegWr  && src_match(hs.IDEX_Rd,  hs.IFID_Rs, hs.IFID_Rt, hs.IFID_UsesRt)) ||
          (hs.EXMEM_MemRd && src_match(hs.EXMEM_Rd, hs.IFID_Rs, hs.IFID_Rt, hs.IFID_UsesRt)));
    hz = lu || br;
    mw = (hs.EXMEM_MemRd || hs.EXMEM_MemWr) && !hs.dmem_ready;

    state_d       = RUN;
    hs.PC_Wr      = 1'b1;
    hs.IFID_Wr    = 1'b1;
    hs.IFID_Flush = 1'b0;
    hs.IDEX_Flush = 1'b0;
    hs.pipe_hold  = 1'b0;

    // A memory wait freezes everything, so a pending hazard bubble must wait too.
    if (mw) begin
      state_d      = MWAIT;
      hs.PC_Wr     = 1'b0;
      hs.IFID_Wr   = 1'b0;
      hs.pipe_hold = 1'b1;
    end else if (hz) begin
      state_d       = STALL;
      hs.PC_Wr      = 1'b0;
      hs.IFID_Wr    = 1'b0;
      hs.IDEX_Flush = 1'b1;
    end else if (hs.branch_taken) begin
      hs.IFID_Flush = 1'b1;
    end
  end

  assign stall_to_stall = (state_q == STALL) && (state_d == STALL);

  always_comb begin
    wait_cnt_d = 8'd0;
    if (mw) wait_cnt_d = (wait_cnt_q == WAIT_LIM) ? wait_cnt_q : wait_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q   <= 2'd0;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= 16'd0;
      mem_err_q   <= 1'b0;
      hz_err_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;

      if (hz && !mw && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;

      if (!stall_to_stall)           run_cnt_q <= 2'd0;
      else if (run_cnt_q != 2'd3)    run_cnt_q <= run_cnt_q + 2'd1;

      // Two back-to-back stall cycles are legal; a third means the hazard is stuck.
      if (stall_to_stall && (run_cnt_q >= 2'd1)) hz_err_q <= 1'b1;
      if (mw && (wait_cnt_d == WAIT_LIM))        mem_err_q <= 1'b1;
    end
  end

  assign hs.stall_cnt = stall_cnt_q;
  assign hs.mem_err   = mem_err_q;
  assign hs.hz_err    = hz_err_q;

endmodule
